sid_pot_adc: RTL and testbench
==============================

Name: sid_pot_adc

Overview:
- Models the SID POTX/POTY paddle converter, the analog-to-digital counterpart of the waveform, cutoff and envelope DAC path.
- Runs a free-running 2×2^BITS-tick measurement frame on the SID 1 MHz clock enable.
  - First half: discharges the external pot capacitors.
  - Second half: counts until each axis comparator trips.
- Latches one result per axis at end of frame, for the register file and bus read mux.

Parameters:
- BITS, 8, result width; half-frame length = 2^BITS ce ticks.
- SYNC_STAGES, 2, flip-flop stages on each comparator input (clk domain, ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  1 MHz SID clock enable, one clk pulse per SID cycle.
- comp_x  in  1  POTX comparator; 1 = capacitor voltage above threshold; asynchronous.
- comp_y  in  1  POTY comparator; same as comp_x.
- discharge  out  1  1 = drive both pot pins low (discharge phase).
- potx  out  BITS  last latched X result.
- poty  out  BITS  last latched Y result.
- valid  out  1  one-clk pulse when potx/poty update.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk.
  - Reset is synchronous, active-high, and overrides ce.
- Reset values:
  - phase=0, discharge=1, potx=0, poty=0, valid=0.
  - Capture flags cleared; synchronizer flops 0.
  - Reset mid-frame abandons the frame: no valid pulse; next frame starts at phase 0 after reset deasserts.
- Synchronizer: comp_x/comp_y pass through SYNC_STAGES flops on every clk (independent of ce). cs_x/cs_y denote the last stage.
- Phase counter:
  - Width BITS+1; advances only when ce=1.
  - Wraps from 2^(BITS+1)-1 to 0.
- Discharge phase (phase MSB=0):
  - discharge=1.
  - cs_x/cs_y ignored; capture flags held 0.
- Charge phase (phase MSB=1):
  - discharge=0.
  - Define cnt = phase[BITS-1:0].
  - On a ce tick with cs_x=1 and cap_x=0: cap_x<=1, res_x<=cnt. Y is identical and independent.
  - Once cap_x=1, further comparator edges are ignored (glitches after trip have no effect).
  - Comparator already high at the first charge tick (cnt=0) gives result 0.
- End of frame (ce tick at phase=2^(BITS+1)-1):
  - potx <= (cap_x or cs_x trips on this tick) ? captured value : 2^BITS-1.
  - Same rule for poty.
  - A trip on the final tick yields 2^BITS-1, so saturation and a last-tick trip are indistinguishable, as in silicon.
  - valid=1 for exactly the clk following that ce tick, else 0.
  - Capture flags cleared for the next frame.
- Latency:
  - A comparator change must be stable ≥SYNC_STAGES clk cycles before a ce tick to be seen at that tick.
  - Results appear on potx/poty 1 clk after the final ce tick.
  - Outputs hold between frames.
- ce timing:
  - ce never asserts on consecutive clks (≥SYNC_STAGES+1 clk spacing guaranteed upstream).
  - No behaviour is defined for closer spacing.

Test Plan:
- Reset, then 512 ce ticks with comp_x=comp_y=0:
  - discharge=1 for ticks 0–255, 0 for ticks 256–511.
  - Single valid pulse; potx=poty=0xFF.
- comp_x rises 3 clk before charge tick cnt=100; comp_y rises before cnt=37:
  - After frame: potx=100 (0x64), poty=37 (0x25), valid once.
- comp_x held 1 through the whole frame, including discharge:
  - Discharge ignored; potx=0.
  - comp_y toggled high at cnt=200 then low at cnt=210: poty=200 (0xC8).
- comp_x rises so it is first seen at the final tick (cnt=255):
  - potx=0xFF.
  - Next frame with comp_x=0 throughout: potx=0xFF again; valid period exactly 512 ce ticks.
- Mid-charge reset:
  - At cnt=50 with comp_x already tripped at cnt=10, assert reset 1 clk.
  - Result: potx=poty=0, no valid, discharge=1.
  - A fresh frame after reset with trip at cnt=80 gives potx=80.
- BITS=4, SYNC_STAGES=3:
  - Frame = 32 ticks; trip at cnt=9 gives potx=9.
  - No trip gives 0xF.
  - Comparator stable only 2 clk before a tick is not seen until the next tick (result = cnt+1).

Source files
------------

// File: rtl/sid_pot_adc.sv
// sid_pot_adc - SID POTX/POTY paddle converter.
//
// A free-running frame of 2*2^BITS ticks of the 1 MHz SID clock enable.
// In the first half both pot capacitors are discharged. In the second half
// a counter runs, and each axis records the count at which its comparator
// first reports the capacitor above threshold. At the end of the frame one
// result per axis is latched, and a one-clk valid strobe is raised.
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   reset      synchronous, active-high reset (overrides ce)
//   ce         SID 1 MHz clock enable, one clk pulse per SID cycle
//   comp_x     POTX comparator, asynchronous, 1 = above threshold
//   comp_y     POTY comparator, asynchronous, 1 = above threshold
//   discharge  1 = drive both pot pins low
//   potx       last latched X result
//   poty       last latched Y result
//   valid      one-clk pulse when potx/poty update
module sid_pot_adc #(
    parameter int BITS        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            comp_x,
    input  logic            comp_y,
    output logic            discharge,
    output logic [BITS-1:0] potx,
    output logic [BITS-1:0] poty,
    output logic            valid
);

    localparam logic [BITS:0]   PHASE_LAST = {(BITS+1){1'b1}};
    localparam logic [BITS:0]   PHASE_ONE  = {{BITS{1'b0}}, 1'b1};
    localparam logic [BITS-1:0] RES_MAX    = {BITS{1'b1}};

    // An axis that never tripped during the charge half saturates. A trip
    // on the very last tick also lands here, which matches silicon.
    function automatic logic [BITS-1:0] frame_result(input logic            cap,
                                                     input logic [BITS-1:0] res);
        if (cap) begin
            frame_result = res;
        end else begin
            frame_result = RES_MAX;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_x_r;
    logic [SYNC_STAGES-1:0] sync_y_r;
    logic                   cs_x_s;
    logic                   cs_y_s;

    logic [BITS:0]          phase_r,     phase_s;
    logic                   cap_x_r,     cap_x_s;
    logic                   cap_y_r,     cap_y_s;
    logic [BITS-1:0]        res_x_r,     res_x_s;
    logic [BITS-1:0]        res_y_r,     res_y_s;
    logic [BITS-1:0]        potx_r,      potx_s;
    logic [BITS-1:0]        poty_r,      poty_s;
    logic                   valid_r,     valid_s;
    logic                   discharge_r, discharge_s;
    logic [BITS-1:0]        cnt_s;

    // Comparator synchronizers, clocked every clk regardless of ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_x_r <= '0;
            sync_y_r <= '0;
        end else begin
            sync_x_r[0] <= comp_x;
            sync_y_r[0] <= comp_y;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_x_r[i] <= sync_x_r[i-1];
                sync_y_r[i] <= sync_y_r[i-1];
            end
        end
    end

    assign cs_x_s = sync_x_r[SYNC_STAGES-1];
    assign cs_y_s = sync_y_r[SYNC_STAGES-1];
    assign cnt_s  = phase_r[BITS-1:0];

    // Next-state logic for the frame counter, capture flags and results.
    always_comb begin
        phase_s     = phase_r;
        cap_x_s     = cap_x_r;
        cap_y_s     = cap_y_r;
        res_x_s     = res_x_r;
        res_y_s     = res_y_r;
        potx_s      = potx_r;
        poty_s      = poty_r;
        valid_s     = 1'b0;
        if (ce) begin
            phase_s = phase_r + PHASE_ONE;
            if (!phase_r[BITS]) begin
                // Discharge half: comparators are meaningless, keep flags clear.
                cap_x_s = 1'b0;
                cap_y_s = 1'b0;
            end else if (phase_r == PHASE_LAST) begin
                potx_s  = frame_result(cap_x_r, res_x_r);
                poty_s  = frame_result(cap_y_r, res_y_r);
                valid_s = 1'b1;
                cap_x_s = 1'b0;
                cap_y_s = 1'b0;
            end else begin
                // First trip wins; later comparator activity is ignored.
                if (cs_x_s && !cap_x_r) begin
                    cap_x_s = 1'b1;
                    res_x_s = cnt_s;
                end else begin
                    cap_x_s = cap_x_r;
                end
                if (cs_y_s && !cap_y_r) begin
                    cap_y_s = 1'b1;
                    res_y_s = cnt_s;
                end else begin
                    cap_y_s = cap_y_r;
                end
            end
        end else begin
            phase_s = phase_r;
        end
        discharge_s = ~phase_s[BITS];
    end

    // Frame state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r     <= '0;
            cap_x_r     <= 1'b0;
            cap_y_r     <= 1'b0;
            res_x_r     <= '0;
            res_y_r     <= '0;
            potx_r      <= '0;
            poty_r      <= '0;
            valid_r     <= 1'b0;
            discharge_r <= 1'b1;
        end else begin
            phase_r     <= phase_s;
            cap_x_r     <= cap_x_s;
            cap_y_r     <= cap_y_s;
            res_x_r     <= res_x_s;
            res_y_r     <= res_y_s;
            potx_r      <= potx_s;
            poty_r      <= poty_s;
            valid_r     <= valid_s;
            discharge_r <= discharge_s;
        end
    end

    assign discharge = discharge_r;
    assign potx      = potx_r;
    assign poty      = poty_r;
    assign valid     = valid_r;

endmodule

// File: tb/tb_sid_pot_adc.sv
// tb_sid_pot_adc - self-checking bench for sid_pot_adc.
//
// Two instances: BITS=8/SYNC_STAGES=2 and BITS=4/SYNC_STAGES=3. Each frame
// is described by a table record (comparator on/off tick windows and the
// expected results). Expected results are pushed to a per-instance queue
// when the frame is started and popped when that instance pulses valid.
// Every comparison lives in the single negedge monitor process.
module tb_sid_pot_adc;

    localparam int BIG = 100000;

    logic       clk = 1'b0;
    logic       reset8, reset4, ce;
    logic       cx8, cy8, cx4, cy4;
    logic       dis8, dis4, valid8, valid4;
    logic [7:0] potx8, poty8;
    logic [3:0] potx4, poty4;

    always #5 clk = ~clk;

    sid_pot_adc #(.BITS(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset8), .ce(ce), .comp_x(cx8), .comp_y(cy8),
        .discharge(dis8), .potx(potx8), .poty(poty8), .valid(valid8)
    );

    sid_pot_adc #(.BITS(4), .SYNC_STAGES(3)) dut4 (
        .clk(clk), .reset(reset4), .ce(ce), .comp_x(cx4), .comp_y(cy4),
        .discharge(dis4), .potx(potx4), .poty(poty4), .valid(valid4)
    );

    // One frame: x high for ticks [xs,xe) applied xd clks into the tick slot,
    // y high for ticks [ys,ye) applied at slot start; expected results.
    typedef struct {
        int xs; int xe; int xd; int ys; int ye; int ex; int ey;
    } vec_t;

    vec_t        v8[5];
    vec_t        v4[3];
    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    // Requests from the stimulus process to the monitor.
    logic armed8 = 1'b0, exp_dis8 = 1'b1, rst_chk8 = 1'b0, rst_chk4 = 1'b0;
    logic per_on8 = 1'b0, done = 1'b0;
    int   ph8 = 0;

    // Monitor state; only the monitor writes these.
    int      checks = 0, errors = 0;
    longint  cyc = 0, last_v8 = -1;
    logic    prev_v8 = 1'b0, prev_v4 = 1'b0;
    logic [15:0] e8;
    logic [7:0]  e4;

    always @(posedge clk) cyc <= cyc + 1;

    // Each tick slot is 4 clks: three with ce=0, then one with ce=1.
    task automatic run_ticks(input int n, input int xs, input int xe, input int xd,
                             input int ys, input int ye, input bit use4);
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == xd) begin
                    if (use4) cx4 = (t >= xs && t < xe);
                    else      cx8 = (t >= xs && t < xe);
                end
                if (c == 0) begin
                    if (use4) cy4 = (t >= ys && t < ye);
                    else      cy8 = (t >= ys && t < ye);
                end
                ce = (c == 3);
                @(posedge clk); #1;
                if (c == 3 && !use4) begin
                    ph8      = (ph8 + 1) % 512;
                    exp_dis8 = (ph8 < 256);
                end
            end
        end
        ce = 1'b0;
    endtask

    // Monitor: all comparisons, sampled on the falling edge.
    always @(negedge clk) begin
        if (armed8) begin
            checks = checks + 1;
            if (dis8 !== exp_dis8) begin
                errors = errors + 1;
                $display("FAIL discharge8 cyc=%0d got=%b exp=%b", cyc, dis8, exp_dis8);
            end
        end
        if (rst_chk8) begin
            checks = checks + 1;
            if ({potx8, poty8, valid8, dis8} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
                errors = errors + 1;
                $display("FAIL reset8 got potx=%h poty=%h valid=%b dis=%b exp 00 00 0 1",
                         potx8, poty8, valid8, dis8);
            end
        end
        if (rst_chk4) begin
            checks = checks + 1;
            if ({potx4, poty4, valid4, dis4} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
                errors = errors + 1;
                $display("FAIL reset4 got potx=%h poty=%h valid=%b dis=%b exp 0 0 0 1",
                         potx4, poty4, valid4, dis4);
            end
        end
        if (valid8 === 1'b1) begin
            checks = checks + 1;
            if (prev_v8) begin
                errors = errors + 1;
                $display("FAIL valid8_width valid high on consecutive clks exp 1-clk pulse");
            end
            if (q8.size() == 0) begin
                errors = errors + 1;
                $display("FAIL valid8_unexpected got valid with potx=%h poty=%h exp none",
                         potx8, poty8);
            end else begin
                e8 = q8.pop_front();
                if ({potx8, poty8} !== e8) begin
                    errors = errors + 1;
                    $display("FAIL result8 got potx=%h poty=%h exp potx=%h poty=%h",
                             potx8, poty8, e8[15:8], e8[7:0]);
                end
            end
            if (per_on8 && last_v8 >= 0) begin
                checks = checks + 1;
                if (cyc - last_v8 != 2048) begin
                    errors = errors + 1;
                    $display("FAIL valid8_period got=%0d clks exp=2048", cyc - last_v8);
                end
            end
            last_v8 = cyc;
        end
        if (valid4 === 1'b1) begin
            checks = checks + 1;
            if (prev_v4) begin
                errors = errors + 1;
                $display("FAIL valid4_width valid high on consecutive clks exp 1-clk pulse");
            end
            if (q4.size() == 0) begin
                errors = errors + 1;
                $display("FAIL valid4_unexpected got valid with potx=%h poty=%h exp none",
                         potx4, poty4);
            end else begin
                e4 = q4.pop_front();
                if ({potx4, poty4} !== e4) begin
                    errors = errors + 1;
                    $display("FAIL result4 got potx=%h poty=%h exp potx=%h poty=%h",
                             potx4, poty4, e4[7:4], e4[3:0]);
                end
            end
        end
        prev_v8 = valid8;
        prev_v4 = valid4;
        if (done) begin
            checks = checks + 1;
            if (q8.size() != 0 || q4.size() != 0) begin
                errors = errors + 1;
                $display("FAIL missing_valid got pending8=%0d pending4=%0d exp 0 0",
                         q8.size(), q4.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        // 8-bit frames, run back to back with no reset in between.
        v8[0] = '{BIG,     BIG, 0, BIG,     BIG,     255, 255}; // no trip
        v8[1] = '{256+100, BIG, 1, 256+37,  BIG,     100, 37};  // x 3 clk early
        v8[2] = '{0,       BIG, 0, 256+200, 256+210, 0,   200}; // x always high
        v8[3] = '{511,     BIG, 0, BIG,     BIG,     255, 255}; // trip at last tick
        v8[4] = '{BIG,     BIG, 0, BIG,     BIG,     255, 255}; // period check
        // 4-bit frames, SYNC_STAGES=3.
        v4[0] = '{16+9,    BIG, 0, BIG,     BIG,     9,   15};
        v4[1] = '{BIG,     BIG, 0, BIG,     BIG,     15,  15};
        v4[2] = '{16+5,    BIG, 2, 16+3,    BIG,     6,   3};   // x seen one tick late

        reset8 = 1'b1; reset4 = 1'b1; ce = 1'b0;
        cx8 = 1'b0; cy8 = 1'b0; cx4 = 1'b0; cy4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        armed8 = 1'b1; rst_chk8 = 1'b1; rst_chk4 = 1'b1;
        @(posedge clk); #1;
        rst_chk8 = 1'b0; rst_chk4 = 1'b0;
        reset8 = 1'b0; ph8 = 0; exp_dis8 = 1'b1;

        for (int i = 0; i < 5; i++) begin
            q8.push_back({v8[i].ex[7:0], v8[i].ey[7:0]});
            if (i == 4) per_on8 = 1'b1;
            run_ticks(512, v8[i].xs, v8[i].xe, v8[i].xd, v8[i].ys, v8[i].ye, 1'b0);
        end
        per_on8 = 1'b0;

        // Reset in mid-charge after x tripped at cnt=10: frame abandoned.
        run_ticks(256+50, 256+10, BIG, 0, BIG, BIG, 1'b0);
        reset8 = 1'b1;
        @(posedge clk); #1;
        reset8 = 1'b0; ph8 = 0; exp_dis8 = 1'b1; rst_chk8 = 1'b1;
        @(posedge clk); #1;
        rst_chk8 = 1'b0;
        q8.push_back({8'd80, 8'hFF});
        run_ticks(512, 256+80, BIG, 0, BIG, BIG, 1'b0);

        // Park the 8-bit instance in reset and exercise the 4-bit one.
        reset8 = 1'b1;
        @(posedge clk); #1;
        exp_dis8 = 1'b1; ph8 = 0;
        reset4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q4.push_back({v4[i].ex[3:0], v4[i].ey[3:0]});
            run_ticks(32, v4[i].xs, v4[i].xe, v4[i].xd, v4[i].ys, v4[i].ye, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_timeout summary not reached");
        $fatal(1);
    end

endmodule
